// File: rtl/fetch_pkg.sv
// Shared fetch types: request FSM states, prefetch entry layout and the bubble instruction word.
package fetch_pkg;

   localparam int FETCH_ADR_W  = 16;
   localparam int FETCH_INST_W = 16;

   localparam logic [FETCH_INST_W-1:0] NOP_INST = 16'h0000;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      DROP
   } fetch_state_t;

   typedef struct packed {
      logic [FETCH_INST_W-1:0] inst;
      logic [FETCH_ADR_W-1:0]  pcinc;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory read port: single outstanding request held until acknowledged.
interface fetch_if
   import fetch_pkg::*;
#(
   parameter int ADR_W  = FETCH_ADR_W,
   parameter int INST_W = FETCH_INST_W
);

   logic              imem_req;
   logic [ADR_W-1:0]  imem_adr;
   logic              imem_ack;
   logic [INST_W-1:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_adr,
      input  imem_ack,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_adr,
      output imem_ack,
      output imem_rdata
   );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of fetched entries; count_rsv adds the slot reserved by an in-flight request.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int  DEPTH   = 2,
   parameter type entry_t = fetch_entry_t
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clear,
   input  logic                 push,
   input  entry_t               push_data,
   input  logic                 pop,
   output entry_t               head,
   input  logic                 reserve,
   output logic                 full,
   output logic                 empty,
   output logic [$clog2(DEPTH):0] count_rsv
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   entry_t             mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [CNT_W-1:0]   count;
   logic               do_push;
   logic               do_pop;

   assign full      = (count == CNT_W'(DEPTH));
   assign empty     = (count == '0);
   assign do_pop    = pop & !empty & !clear;
   assign do_push   = push & !clear & (!full | do_pop);
   assign head      = mem[rd_ptr];
   assign count_rsv = count + {{PTR_W{1'b0}}, reserve};

   // Clear drops everything, including a push or pop presented in the same cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC and request FSM, prefetch FIFO, and the IF/ID register feeding decode.
module fetch_stage
   import fetch_pkg::*;
#(
   parameter int                ADR_W      = FETCH_ADR_W,
   parameter int                INST_W     = FETCH_INST_W,
   parameter int                FIFO_DEPTH = 2,
   parameter logic [ADR_W-1:0]  RESET_PC   = '0,
   parameter logic [INST_W-1:0] NOP_INST   = fetch_pkg::NOP_INST
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en_pc,
   input  logic              en_ifid,
   input  logic              flush_ifid,
   input  logic              jump_pred,
   input  logic [ADR_W-1:0]  jump_pred_adr,
   input  logic              jump_pred_miss,
   input  logic [ADR_W-1:0]  pcinc_evac,
   input  logic              jump_pred_adr_miss,
   input  logic [ADR_W-1:0]  jump_adr_ex,
   input  logic              halt,
   fetch_if.master           imem,
   output logic [INST_W-1:0] inst_id,
   output logic [ADR_W-1:0]  pcinc_id,
   output logic              flushed
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   typedef struct packed {
      logic [INST_W-1:0] inst;
      logic [ADR_W-1:0]  pcinc;
   } entry_t;

   fetch_state_t     state;
   fetch_state_t     state_nx;
   logic [ADR_W-1:0] pc;
   logic [ADR_W-1:0] pc_nx;
   logic [ADR_W-1:0] adr_q;
   logic [ADR_W-1:0] adr_nx;
   logic             halt_q;
   logic             redirect;
   logic [ADR_W-1:0] redirect_adr;
   logic             issue_ok;
   logic             ack;
   logic             fifo_push;
   logic             fifo_pop;
   logic             fifo_full;
   logic             fifo_empty;
   entry_t           push_data;
   entry_t           head;
   logic [CNT_W-1:0] count_rsv;

   assign imem.imem_req = (state == WAIT) || (state == DROP);
   assign imem.imem_adr = adr_q;
   assign ack           = imem.imem_ack & imem.imem_req;
   assign issue_ok      = en_pc & !halt & !halt_q & !fifo_full & (count_rsv < CNT_W'(FIFO_DEPTH));
   assign push_data     = '{inst: imem.imem_rdata, pcinc: adr_q + 1'b1};
   assign fifo_pop      = en_ifid & !fifo_empty & !flush_ifid & !redirect;

   // A prediction only counts when decode actually consumes a valid instruction.
   always_comb begin
      redirect     = 1'b0;
      redirect_adr = pc;
      if (jump_pred_miss) begin
         redirect     = 1'b1;
         redirect_adr = pcinc_evac;
      end else if (jump_pred_adr_miss) begin
         redirect     = 1'b1;
         redirect_adr = jump_adr_ex;
      end else if (jump_pred & en_ifid & !flushed) begin
         redirect     = 1'b1;
         redirect_adr = jump_pred_adr;
      end
   end

   always_comb begin
      state_nx  = state;
      pc_nx     = pc;
      adr_nx    = adr_q;
      fifo_push = 1'b0;
      case (state)
         IDLE: begin
            if (redirect) begin
               pc_nx = redirect_adr;
            end else if (issue_ok) begin
               state_nx = WAIT;
               adr_nx   = pc;
            end
         end
         WAIT: begin
            if (ack) begin
               state_nx = IDLE;
               if (redirect) begin
                  pc_nx = redirect_adr;
               end else begin
                  fifo_push = 1'b1;
                  pc_nx     = pc + 1'b1;
               end
            end else if (redirect) begin
               state_nx = DROP;
               pc_nx    = redirect_adr;
            end
         end
         DROP: begin
            if (redirect) pc_nx = redirect_adr;
            if (ack) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         pc     <= RESET_PC;
         adr_q  <= RESET_PC;
         halt_q <= 1'b0;
      end else begin
         state  <= state_nx;
         pc     <= pc_nx;
         adr_q  <= adr_nx;
         halt_q <= halt_q | halt;
      end
   end

   // Bubbles leave pcinc_id untouched; decode qualifies it with flushed.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         inst_id  <= NOP_INST;
         pcinc_id <= '0;
         flushed  <= 1'b1;
      end else if (flush_ifid | redirect) begin
         inst_id <= NOP_INST;
         flushed <= 1'b1;
      end else if (fifo_pop) begin
         inst_id  <= head.inst;
         pcinc_id <= head.pcinc;
         flushed  <= 1'b0;
      end else if (en_ifid) begin
         inst_id <= NOP_INST;
         flushed <= 1'b1;
      end
   end

   fetch_fifo #(
      .DEPTH   (FIFO_DEPTH),
      .entry_t (entry_t)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .clear     (redirect),
      .push      (fifo_push),
      .push_data (push_data),
      .pop       (fifo_pop),
      .head      (head),
      .reserve   (state == WAIT),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count_rsv (count_rsv)
   );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a latency-programmable instruction-memory responder.
module tb_fetch_stage;
   import fetch_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        en_pc, en_ifid, flush_ifid, jump_pred, jump_pred_miss, jump_pred_adr_miss, halt;
   logic [15:0] jump_pred_adr, pcinc_evac, jump_adr_ex;
   logic [15:0] inst_id, pcinc_id;
   logic        flushed;

   int          vectors = 0;
   int          miscompares = 0;

   bit          mem_auto = 1'b1;
   int          mem_lat = 1;
   int          mem_cnt = 0;
   logic        man_ack = 1'b0;
   logic [15:0] man_rdata = 16'h0;

   fetch_if #(.ADR_W(16), .INST_W(16)) bus ();

   fetch_stage dut (
      .clk                (clk),
      .reset              (reset),
      .en_pc              (en_pc),
      .en_ifid            (en_ifid),
      .flush_ifid         (flush_ifid),
      .jump_pred          (jump_pred),
      .jump_pred_adr      (jump_pred_adr),
      .jump_pred_miss     (jump_pred_miss),
      .pcinc_evac         (pcinc_evac),
      .jump_pred_adr_miss (jump_pred_adr_miss),
      .jump_adr_ex        (jump_adr_ex),
      .halt               (halt),
      .imem               (bus),
      .inst_id            (inst_id),
      .pcinc_id           (pcinc_id),
      .flushed            (flushed)
   );

   always #5 clk = ~clk;

   // Memory acks mem_lat negedges after seeing the request, for exactly one cycle, with rdata = adr ^ A5A5.
   always @(negedge clk) begin
      if (!mem_auto) begin
         bus.imem_ack   = man_ack;
         bus.imem_rdata = man_rdata;
         mem_cnt        = 0;
      end else if (bus.imem_ack) begin
         bus.imem_ack = 1'b0;
         mem_cnt      = 0;
      end else if (bus.imem_req) begin
         mem_cnt = mem_cnt + 1;
         if (mem_cnt >= mem_lat) begin
            bus.imem_ack   = 1'b1;
            bus.imem_rdata = bus.imem_adr ^ 16'hA5A5;
         end
      end else begin
         mem_cnt = 0;
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic do_reset();
      reset              = 1'b0;
      en_pc              = 1'b0;
      en_ifid            = 1'b0;
      flush_ifid         = 1'b0;
      jump_pred          = 1'b0;
      jump_pred_miss     = 1'b0;
      jump_pred_adr_miss = 1'b0;
      halt               = 1'b0;
      jump_pred_adr      = 16'h0;
      pcinc_evac         = 16'h0;
      jump_adr_ex        = 16'h0;
      mem_auto           = 1'b1;
      mem_lat            = 1;
      man_ack            = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      vectors++; if (bus.imem_req !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_req: got %b want 0", bus.imem_req); end
      vectors++; if (bus.imem_adr !== 16'h0000) begin miscompares++; $display("[TB] FAIL rst_adr: got %h want 0000", bus.imem_adr); end
      vectors++; if (inst_id !== 16'h0000) begin miscompares++; $display("[TB] FAIL rst_inst: got %h want 0000", inst_id); end
      vectors++; if (pcinc_id !== 16'h0000) begin miscompares++; $display("[TB] FAIL rst_pcinc: got %h want 0000", pcinc_id); end
      vectors++; if (flushed !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_flushed: got %b want 1", flushed); end
   endtask

   task automatic test_stream();
      int got;
      logic [15:0] exp_pc;
      do_reset();
      en_pc   = 1'b1;
      en_ifid = 1'b1;
      repeat (2) @(negedge clk);
      vectors++; if (flushed !== 1'b1) begin miscompares++; $display("[TB] FAIL stream_first_bubble: got %b want 1", flushed); end
      @(negedge clk);
      vectors++; if (flushed !== 1'b0) begin miscompares++; $display("[TB] FAIL stream_first_valid: got %b want 0", flushed); end
      vectors++; if (inst_id !== 16'hA5A5) begin miscompares++; $display("[TB] FAIL stream_first_inst: got %h want A5A5", inst_id); end
      vectors++; if (pcinc_id !== 16'h0001) begin miscompares++; $display("[TB] FAIL stream_first_pcinc: got %h want 0001", pcinc_id); end
      got    = 0;
      exp_pc = 16'h0002;
      for (int cyc = 0; cyc < 20 && got < 4; cyc++) begin
         @(negedge clk);
         if (flushed === 1'b0) begin
            vectors++;
            if (pcinc_id !== exp_pc || inst_id !== ((exp_pc - 16'h1) ^ 16'hA5A5)) begin
               miscompares++;
               $display("[TB] FAIL stream_seq: got inst %h pcinc %h want inst %h pcinc %h",
                        inst_id, pcinc_id, (exp_pc - 16'h1) ^ 16'hA5A5, exp_pc);
            end
            exp_pc = exp_pc + 16'h1;
            got++;
         end
      end
      vectors++; if (got != 4) begin miscompares++; $display("[TB] FAIL stream_timeout: got %0d entries want 4", got); end
   endtask

   task automatic test_fifo_fill();
      do_reset();
      en_pc = 1'b1;
      repeat (6) @(negedge clk);
      vectors++; if (bus.imem_req !== 1'b0) begin miscompares++; $display("[TB] FAIL fill_req_stalled: got %b want 0", bus.imem_req); end
      vectors++; if (bus.imem_adr !== 16'h0001) begin miscompares++; $display("[TB] FAIL fill_last_adr: got %h want 0001", bus.imem_adr); end
      vectors++; if (flushed !== 1'b1) begin miscompares++; $display("[TB] FAIL fill_hold: got %b want 1", flushed); end
      en_ifid = 1'b1;
      @(negedge clk);
      vectors++; if (inst_id !== 16'hA5A5 || pcinc_id !== 16'h0001 || flushed !== 1'b0) begin miscompares++; $display("[TB] FAIL fill_drain0: got %h/%h/%b want A5A5/0001/0", inst_id, pcinc_id, flushed); end
      @(negedge clk);
      vectors++; if (inst_id !== 16'hA5A4 || pcinc_id !== 16'h0002 || flushed !== 1'b0) begin miscompares++; $display("[TB] FAIL fill_drain1: got %h/%h/%b want A5A4/0002/0", inst_id, pcinc_id, flushed); end
      vectors++; if (bus.imem_req !== 1'b1 || bus.imem_adr !== 16'h0002) begin miscompares++; $display("[TB] FAIL fill_reissue: got req %b adr %h want 1/0002", bus.imem_req, bus.imem_adr); end
      @(negedge clk);
      vectors++; if (flushed !== 1'b1) begin miscompares++; $display("[TB] FAIL fill_empty_bubble: got %b want 1", flushed); end
      @(negedge clk);
      vectors++; if (inst_id !== 16'hA5A7 || pcinc_id !== 16'h0003 || flushed !== 1'b0) begin miscompares++; $display("[TB] FAIL fill_next: got %h/%h/%b want A5A7/0003/0", inst_id, pcinc_id, flushed); end
   endtask

   task automatic test_jump_pred();
      do_reset();
      en_pc   = 1'b1;
      en_ifid = 1'b1;
      repeat (2) @(negedge clk);
      mem_lat = 3;
      @(negedge clk);
      vectors++; if (flushed !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_adr !== 16'h0001) begin miscompares++; $display("[TB] FAIL jp_setup: got flushed %b req %b adr %h want 0/1/0001", flushed, bus.imem_req, bus.imem_adr); end
      jump_pred     = 1'b1;
      jump_pred_adr = 16'h0040;
      @(negedge clk);
      jump_pred = 1'b0;
      vectors++; if (flushed !== 1'b1 || bus.imem_req !== 1'b1 || bus.imem_adr !== 16'h0001) begin miscompares++; $display("[TB] FAIL jp_drop_held: got flushed %b req %b adr %h want 1/1/0001", flushed, bus.imem_req, bus.imem_adr); end
      for (int c = 5; c <= 10; c++) begin
         @(negedge clk);
         vectors++; if (flushed !== 1'b1) begin miscompares++; $display("[TB] FAIL jp_bubble_c%0d: got %b want 1", c, flushed); end
         if (c == 6) begin
            vectors++; if (bus.imem_req !== 1'b0) begin miscompares++; $display("[TB] FAIL jp_idle: got req %b want 0", bus.imem_req); end
         end
         if (c == 7) begin
            vectors++; if (bus.imem_req !== 1'b1 || bus.imem_adr !== 16'h0040) begin miscompares++; $display("[TB] FAIL jp_target_req: got req %b adr %h want 1/0040", bus.imem_req, bus.imem_adr); end
         end
      end
      @(negedge clk);
      vectors++; if (inst_id !== 16'hA5E5 || pcinc_id !== 16'h0041 || flushed !== 1'b0) begin miscompares++; $display("[TB] FAIL jp_target_inst: got %h/%h/%b want A5E5/0041/0", inst_id, pcinc_id, flushed); end
   endtask

   task automatic test_double_miss();
      do_reset();
      en_pc              = 1'b1;
      en_ifid            = 1'b1;
      jump_pred_miss     = 1'b1;
      jump_pred_adr_miss = 1'b1;
      pcinc_evac         = 16'h0011;
      jump_adr_ex        = 16'h0080;
      @(negedge clk);
      jump_pred_miss     = 1'b0;
      jump_pred_adr_miss = 1'b0;
      @(negedge clk);
      vectors++; if (bus.imem_req !== 1'b1 || bus.imem_adr !== 16'h0011) begin miscompares++; $display("[TB] FAIL miss_prio_adr: got req %b adr %h want 1/0011", bus.imem_req, bus.imem_adr); end
      repeat (2) @(negedge clk);
      vectors++; if (inst_id !== 16'hA5B4 || pcinc_id !== 16'h0012 || flushed !== 1'b0) begin miscompares++; $display("[TB] FAIL miss_prio_inst: got %h/%h/%b want A5B4/0012/0", inst_id, pcinc_id, flushed); end
   endtask

   task automatic test_wrap();
      do_reset();
      en_pc          = 1'b1;
      en_ifid        = 1'b1;
      jump_pred_miss = 1'b1;
      pcinc_evac     = 16'hFFFF;
      @(negedge clk);
      jump_pred_miss = 1'b0;
      @(negedge clk);
      vectors++; if (bus.imem_adr !== 16'hFFFF) begin miscompares++; $display("[TB] FAIL wrap_top_adr: got %h want FFFF", bus.imem_adr); end
      repeat (2) @(negedge clk);
      vectors++; if (inst_id !== 16'h5A5A || pcinc_id !== 16'h0000 || flushed !== 1'b0) begin miscompares++; $display("[TB] FAIL wrap_pcinc: got %h/%h/%b want 5A5A/0000/0", inst_id, pcinc_id, flushed); end
      vectors++; if (bus.imem_req !== 1'b1 || bus.imem_adr !== 16'h0000) begin miscompares++; $display("[TB] FAIL wrap_next_adr: got req %b adr %h want 1/0000", bus.imem_req, bus.imem_adr); end
   endtask

   task automatic test_halt();
      do_reset();
      en_pc   = 1'b1;
      en_ifid = 1'b1;
      halt    = 1'b1;
      @(negedge clk);
      halt = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         vectors++; if (bus.imem_req !== 1'b0) begin miscompares++; $display("[TB] FAIL halt_sticky_c%0d: got req %b want 0", c, bus.imem_req); end
      end
   endtask

   task automatic test_reset_mid_wait();
      do_reset();
      en_pc          = 1'b1;
      en_ifid        = 1'b1;
      mem_lat        = 3;
      jump_pred_miss = 1'b1;
      pcinc_evac     = 16'h0030;
      @(negedge clk);
      jump_pred_miss = 1'b0;
      @(negedge clk);
      vectors++; if (bus.imem_req !== 1'b1 || bus.imem_adr !== 16'h0030) begin miscompares++; $display("[TB] FAIL rmw_wait: got req %b adr %h want 1/0030", bus.imem_req, bus.imem_adr); end
      mem_auto = 1'b0;
      #2 reset = 1'b0;
      @(negedge clk);
      man_ack   = 1'b1;
      man_rdata = 16'h1234;
      repeat (2) @(posedge clk);
      @(negedge clk);
      man_ack = 1'b0;
      repeat (2) @(negedge clk);
      vectors++; if (bus.imem_req !== 1'b0 || bus.imem_adr !== 16'h0000) begin miscompares++; $display("[TB] FAIL rmw_bus: got req %b adr %h want 0/0000", bus.imem_req, bus.imem_adr); end
      vectors++; if (inst_id !== 16'h0000 || pcinc_id !== 16'h0000 || flushed !== 1'b1) begin miscompares++; $display("[TB] FAIL rmw_ifid: got %h/%h/%b want 0000/0000/1", inst_id, pcinc_id, flushed); end
      mem_auto = 1'b1;
      mem_lat  = 1;
      reset    = 1'b1;
      @(negedge clk);
      vectors++; if (bus.imem_req !== 1'b1 || bus.imem_adr !== 16'h0000) begin miscompares++; $display("[TB] FAIL rmw_first_req: got req %b adr %h want 1/0000", bus.imem_req, bus.imem_adr); end
      repeat (2) @(negedge clk);
      vectors++; if (inst_id !== 16'hA5A5 || pcinc_id !== 16'h0001 || flushed !== 1'b0) begin miscompares++; $display("[TB] FAIL rmw_first_inst: got %h/%h/%b want A5A5/0001/0", inst_id, pcinc_id, flushed); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_fifo_fill();
      test_jump_pred();
      test_double_miss();
      test_wrap();
      test_halt();
      test_reset_mid_wait();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
